frame_test_sequencer: RTL and testbench

Run controller for the scrambled-frame loopback test. It sequences a programmed number of frames through the transmit scrambler by driving its seed pulse and enable window. It then collects the per-bit `DataWrong` flags returned by the frame data checker and reports an error count and a pass/fail verdict. It sits between the register/test-control logic and the scrambler-plus-checker datapath.

---
 rtl/frame_test_sequencer_if.sv | 27 ++
 rtl/frame_test_sequencer.sv | 144 ++++++++++++++
 tb/tb_frame_test_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/frame_test_sequencer_if.sv
// Control/status and scrambler/checker signals of the frame loopback test sequencer.
// master = test-control + datapath side, slave = the sequencer itself.
interface frame_test_sequencer_if;
  logic        Start;
  logic        Abort;
  logic [15:0] FrameLen;
  logic [7:0]  GapLen;
  logic [7:0]  FrameCount;
  logic        DataWrong;
  logic        FrameStart;
  logic        DataOutEn;
  logic        Busy;
  logic        Done;
  logic        Pass;
  logic [15:0] ErrorCount;
  logic [7:0]  FramesSent;

  modport master (
    output Start, Abort, FrameLen, GapLen, FrameCount, DataWrong,
    input  FrameStart, DataOutEn, Busy, Done, Pass, ErrorCount, FramesSent
  );

  modport slave (
    input  Start, Abort, FrameLen, GapLen, FrameCount, DataWrong,
    output FrameStart, DataOutEn, Busy, Done, Pass, ErrorCount, FramesSent
  );
endinterface

// File: rtl/frame_test_sequencer.sv
// Sequences seed pulse / enable windows for N frames, counts checker errors, reports verdict.
// All outputs registered (FrameStart one cycle after Start); no backpressure, Abort returns to IDLE next edge.
module frame_test_sequencer (
  input  logic                   Clock,
  input  logic                   Reset,
  frame_test_sequencer_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_FRAME, S_GAP, S_DRAIN, S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_len_m1;
  logic [7:0]  r_gap;
  logic [7:0]  r_nframes;
  logic [15:0] r_cnt;
  logic        r_frame_start;
  logic        r_data_out_en;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] r_err_cnt;
  logic [7:0]  r_frames_sent;

  logic        w_count_err;
  logic [15:0] w_err_next;
  logic        w_cnt_zero;
  logic        w_last_frame;

  // DataWrong only counts while the datapath is in use (SEED..DRAIN)
  assign w_count_err  = io_bus.DataWrong &&
                        (r_state == S_SEED || r_state == S_FRAME ||
                         r_state == S_GAP  || r_state == S_DRAIN);
  assign w_err_next   = (w_count_err && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
  assign w_cnt_zero   = (r_cnt == 16'd0);
  assign w_last_frame = ((r_frames_sent + 8'd1) == r_nframes);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_len_m1      <= 16'd0;
      r_gap         <= 8'd0;
      r_nframes     <= 8'd0;
      r_cnt         <= 16'd0;
      r_frame_start <= 1'b0;
      r_data_out_en <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_cnt     <= 16'd0;
      r_frames_sent <= 8'd0;
    end else begin
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      if (r_state != S_IDLE && io_bus.Abort) begin
        r_state       <= S_IDLE;
        r_data_out_en <= 1'b0;
        r_busy        <= 1'b0;
        r_pass        <= 1'b0;
      end else begin
        r_err_cnt <= w_err_next;
        case (r_state)
          S_IDLE: begin
            if (io_bus.Start && !io_bus.Abort) begin
              r_len_m1      <= (io_bus.FrameLen == 16'd0) ? 16'd0 : io_bus.FrameLen - 16'd1;
              r_gap         <= io_bus.GapLen;
              r_nframes     <= io_bus.FrameCount;
              r_err_cnt     <= 16'd0;
              r_frames_sent <= 8'd0;
              r_pass        <= 1'b0;
              r_busy        <= 1'b1;
              // An empty run still spends one DRAIN cycle so Done lands two cycles after Start
              if (io_bus.FrameCount == 8'd0) begin
                r_state <= S_DRAIN;
                r_cnt   <= 16'd0;
              end else begin
                r_state       <= S_SEED;
                r_frame_start <= 1'b1;
              end
            end
          end
          S_SEED: begin
            r_state       <= S_FRAME;
            r_cnt         <= r_len_m1;
            r_data_out_en <= 1'b1;
          end
          S_FRAME: begin
            if (w_cnt_zero) begin
              r_frames_sent <= r_frames_sent + 8'd1;
              r_data_out_en <= 1'b0;
              if (w_last_frame) begin
                r_state <= S_DRAIN;
                r_cnt   <= 16'd2;
              end else if (r_gap == 8'd0) begin
                r_state       <= S_SEED;
                r_frame_start <= 1'b1;
              end else begin
                r_state <= S_GAP;
                r_cnt   <= {8'd0, r_gap - 8'd1};
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_GAP: begin
            if (w_cnt_zero) begin
              r_state       <= S_SEED;
              r_frame_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_DRAIN: begin
            if (w_cnt_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 16'd0);
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.FrameStart = r_frame_start;
  assign io_bus.DataOutEn  = r_data_out_en;
  assign io_bus.Busy       = r_busy;
  assign io_bus.Done       = r_done;
  assign io_bus.Pass       = r_pass;
  assign io_bus.ErrorCount = r_err_cnt;
  assign io_bus.FramesSent = r_frames_sent;

endmodule

// File: tb/tb_frame_test_sequencer.sv
// Directed bench for frame_test_sequencer; cycle k = value sampled by the k-th edge after Start.
module tb_frame_test_sequencer;
  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  logic [31:0] fs_v, doe_v, done_v, busy_v;
  int          done_n, fs_n, done_cyc;
  logic        pass_at_done;
  logic [15:0] err_at_done;
  logic [7:0]  frames_at_done;

  frame_test_sequencer_if bus ();

  frame_test_sequencer dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .io_bus (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is cycle 0.
  task automatic start(input logic [7:0] fc, input logic [15:0] fl, input logic [7:0] gl);
    bus.FrameCount = fc;
    bus.FrameLen   = fl;
    bus.GapLen     = gl;
    bus.Start      = 1'b1;
  endtask

  // Record outputs for cycles 1..ncyc; DataWrong/Abort driven so that cycle k samples them.
  task automatic run(input int ncyc, input logic [31:0] dw_mask, input int abort_cyc);
    fs_v = '0; doe_v = '0; done_v = '0; busy_v = '0; done_n = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge Clock);
      if (k < 32) begin
        fs_v[k]   = bus.FrameStart;
        doe_v[k]  = bus.DataOutEn;
        done_v[k] = bus.Done;
        busy_v[k] = bus.Busy;
      end
      if (bus.Done) begin
        done_n++;
        pass_at_done   = bus.Pass;
        err_at_done    = bus.ErrorCount;
        frames_at_done = bus.FramesSent;
      end
      bus.Start     = 1'b0;
      bus.DataWrong = (k < 32) ? dw_mask[k] : 1'b0;
      bus.Abort     = (k == abort_cyc);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    pass_at_done = 1'b0; err_at_done = '0; frames_at_done = '0;
    Reset = 1'b0;
    bus.Start = 1'b0; bus.Abort = 1'b0; bus.DataWrong = 1'b0;
    bus.FrameLen = '0; bus.GapLen = '0; bus.FrameCount = '0;
    @(negedge Clock); @(negedge Clock);
    chk("reset_outputs", {3'd0, bus.FrameStart, bus.DataOutEn, bus.Busy, bus.Done, bus.Pass,
                          bus.ErrorCount, bus.FramesSent}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // N=2 L=4 G=3, clean
    start(8'd2, 16'd4, 8'd3);
    run(20, 32'h0, 0);
    chk("t1_framestart", fs_v, 32'h0000_0202);
    chk("t1_dataouten", doe_v, 32'h0000_3C3C);
    chk("t1_done", done_v, 32'h0002_0000);
    chk("t1_busy", busy_v, 32'h0003_FFFE);
    chk("t1_pass", {31'd0, pass_at_done}, 32'd1);
    chk("t1_errcnt", {16'd0, err_at_done}, 32'd0);
    chk("t1_frames", {24'd0, frames_at_done}, 32'd2);

    // Same run, errors in cycles 10,11,12 (frame 2) and 15 (drain)
    start(8'd2, 16'd4, 8'd3);
    run(20, 32'h0000_9C00, 0);
    chk("t2_done", done_v, 32'h0002_0000);
    chk("t2_errcnt", {16'd0, err_at_done}, 32'd4);
    chk("t2_pass", {31'd0, pass_at_done}, 32'd0);

    // N=3 L=0 G=0
    start(8'd3, 16'd0, 8'd0);
    run(14, 32'h0, 0);
    chk("t3_framestart", fs_v, 32'h0000_002A);
    chk("t3_dataouten", doe_v, 32'h0000_0054);
    chk("t3_done", done_v, 32'h0000_0400);
    chk("t3_frames", {24'd0, frames_at_done}, 32'd3);
    chk("t3_pass", {31'd0, pass_at_done}, 32'd1);

    // Abort in cycle 6 (first gap cycle)
    start(8'd2, 16'd4, 8'd3);
    run(20, 32'h0, 6);
    chk("t4_framestart", fs_v, 32'h0000_0002);
    chk("t4_dataouten", doe_v, 32'h0000_003C);
    chk("t4_busy", busy_v, 32'h0000_007E);
    chk("t4_done", done_v, 32'h0);
    chk("t4_pass", {31'd0, bus.Pass}, 32'd0);
    chk("t4_frames", {24'd0, bus.FramesSent}, 32'd1);

    // Start and Abort together in IDLE: nothing happens, counters untouched
    bus.Abort = 1'b1;
    start(8'd1, 16'd1, 8'd0);
    run(6, 32'h0, 0);
    chk("t5_busy", busy_v, 32'h0);
    chk("t5_framestart", fs_v, 32'h0);
    chk("t5_frames", {24'd0, bus.FramesSent}, 32'd1);

    // FrameCount=0
    start(8'd0, 16'd5, 8'd5);
    run(6, 32'h0, 0);
    chk("t6_done", done_v, 32'h0000_0004);
    chk("t6_busy", busy_v, 32'h0000_0006);
    chk("t6_activity", fs_v | doe_v, 32'h0);
    chk("t6_pass", {31'd0, pass_at_done}, 32'd1);

    // Reset mid-FRAME, then a normal run
    start(8'd2, 16'd4, 8'd3);
    run(3, 32'h0000_0002, 0);
    chk("t7_pre_busy", {31'd0, bus.DataOutEn}, 32'd1);
    chk("t7_pre_errcnt", {16'd0, bus.ErrorCount}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("t7_reset_outputs", {3'd0, bus.FrameStart, bus.DataOutEn, bus.Busy, bus.Done, bus.Pass,
                             bus.ErrorCount, bus.FramesSent}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    start(8'd1, 16'd2, 8'd0);
    run(10, 32'h0, 0);
    chk("t7_framestart", fs_v, 32'h0000_0002);
    chk("t7_dataouten", doe_v, 32'h0000_000C);
    chk("t7_done", done_v, 32'h0000_0080);
    chk("t7_frames", {24'd0, frames_at_done}, 32'd1);
    chk("t7_pass", {31'd0, pass_at_done}, 32'd1);

    // N=1 L=65535 with DataWrong held high; second Start while busy
    start(8'd1, 16'hFFFF, 8'd0);
    bus.DataWrong = 1'b1;
    done_n = 0; fs_n = 0; done_cyc = 0;
    for (int k = 1; k <= 70000; k++) begin
      @(negedge Clock);
      if (bus.Done) begin
        done_n++;
        done_cyc       = k;
        pass_at_done   = bus.Pass;
        err_at_done    = bus.ErrorCount;
        frames_at_done = bus.FramesSent;
      end
      if (bus.FrameStart) fs_n++;
      bus.Start = 1'b0;
      if (k == 100) begin
        bus.FrameCount = 8'd5;
        bus.Start      = 1'b1;
      end
    end
    bus.DataWrong = 1'b0;
    chk("t8_done_count", done_n, 32'd1);
    chk("t8_done_cycle", done_cyc, 32'd65540);
    chk("t8_seed_count", fs_n, 32'd1);
    chk("t8_errcnt_sat", {16'd0, err_at_done}, 32'h0000_FFFF);
    chk("t8_pass", {31'd0, pass_at_done}, 32'd0);
    chk("t8_frames", {24'd0, frames_at_done}, 32'd1);
    chk("t8_idle_hold", {16'd0, bus.ErrorCount}, 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
